btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_pkg.sv | 6 +
 rtl/sync_2ff.sv | 12 +
 rtl/btn_debounce.sv | 82 ++++++++
 tb/tb_btn_debounce.sv | 115 +++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding and default timing constants for button debouncing
package btn_pkg;
   typedef enum logic [1:0] {ST_LOW, ST_WAIT_HIGH, ST_HIGH, ST_WAIT_LOW} btn_state_t;
   localparam int DEBOUNCE_CYCLES_DEF = 120_000;
   localparam int LONG_CYCLES_DEF     = 12_000_000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit, resets to 0
module sync_2ff (
   input  logic pllclk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge pllclk or negedge rst_n)
      if (!rst_n) {q, meta} <= 2'b00;
      else        {q, meta} <= {meta, d};
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: debounced button level with press/release/long-press pulses
// The long-press hold counter exists only when BTN_DEBOUNCE_LONGPRESS_EN is defined.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic hwclk,
   input  logic reset_btn,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_long
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_END = CW'(DEBOUNCE_CYCLES - 2);
   btn_state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic sync, level_nx, press_nx, release_nx;

   sync_2ff u_sync (.pllclk(hwclk), .rst_n(reset_btn), .d(btn_in), .q(sync));

   always_ff @(posedge hwclk or negedge reset_btn)
      if (!reset_btn) begin
         state       <= ST_LOW;
         cnt         <= '0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         btn_level   <= level_nx;
         btn_press   <= press_nx;
         btn_release <= release_nx;
      end

   // The counter only runs while waiting and stops at CNT_END, so it never wraps.
   always_comb begin
      state_nx = state;
      cnt_nx   = '0;
      case (state)
         ST_LOW:       state_nx = sync ? ST_WAIT_HIGH : ST_LOW;
         ST_WAIT_HIGH: begin
            state_nx = !sync ? ST_LOW : (cnt == CNT_END) ? ST_HIGH : ST_WAIT_HIGH;
            cnt_nx   = (sync && cnt != CNT_END) ? cnt + 1'b1 : '0;
         end
         ST_HIGH:      state_nx = sync ? ST_HIGH : ST_WAIT_LOW;
         ST_WAIT_LOW:  begin
            state_nx = sync ? ST_HIGH : (cnt == CNT_END) ? ST_LOW : ST_WAIT_LOW;
            cnt_nx   = (!sync && cnt != CNT_END) ? cnt + 1'b1 : '0;
         end
         default:      state_nx = ST_LOW;
      endcase
   end

   always_comb begin
      level_nx   = state_nx inside {ST_HIGH, ST_WAIT_LOW};
      press_nx   = level_nx & ~btn_level;
      release_nx = ~level_nx & btn_level;
   end

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
   localparam int LW = $clog2(LONG_CYCLES + 1);
   localparam logic [LW-1:0] HOLD_FIRE = LW'(LONG_CYCLES - 1);
   localparam logic [LW-1:0] HOLD_SAT  = LW'(LONG_CYCLES);
   logic [LW-1:0] hold;
   // Saturating one past the fire value makes the pulse one-shot per press.
   always_ff @(posedge hwclk or negedge reset_btn)
      if (!reset_btn) begin
         hold     <= '0;
         btn_long <= 1'b0;
      end else begin
         hold     <= press_nx ? '0 : (btn_level && hold != HOLD_SAT) ? hold + 1'b1 : hold;
         btn_long <= btn_level && hold == HOLD_FIRE;
      end
`else
   assign btn_long = 1'b0;
`endif
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: randomized scoreboard bench for btn_debounce against a run-length reference model
module tb_btn_debounce;
   localparam int DEB  = 4;
   localparam int LONG = 10;
   logic hwclk = 1'b0, reset_btn = 1'b0, btn_in = 1'b0;
   logic btn_level, btn_press, btn_release, btn_long;
   int checks = 0, errors = 0;
   logic [3:0] exp_q[$];
   logic [3:0] mon_exp;
   bit started = 0;
   bit pipe[$];
   int run = 0, since = LONG + 1;
   bit lvl = 0;

   btn_debounce #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
      .hwclk(hwclk), .reset_btn(reset_btn), .btn_in(btn_in),
      .btn_level(btn_level), .btn_press(btn_press),
      .btn_release(btn_release), .btn_long(btn_long)
   );

   always #5 hwclk = ~hwclk;

   // Level flips once the input, seen two edges late, has differed from it for DEB edges in a row.
   task automatic model_edge(input bit b, input bit r);
      bit s, prev, lng;
      if (!r) begin
         pipe.delete();
         pipe.push_back(1'b0);
         pipe.push_back(1'b0);
         lvl   = 0;
         run   = 0;
         since = LONG + 1;
         exp_q.push_back(4'b0000);
      end else begin
         s = pipe.pop_front();
         pipe.push_back(b);
         prev = lvl;
         run  = (s != lvl) ? run + 1 : 0;
         if (run == DEB) begin
            lvl = ~lvl;
            run = 0;
         end
         if (prev) since++;
         lng = (since == LONG);
`ifndef BTN_DEBOUNCE_LONGPRESS_EN
         lng = 0;
`endif
         if (lvl && !prev) since = 0;
         exp_q.push_back({lvl, lvl & ~prev, ~lvl & prev, lng});
      end
   endtask

   task automatic step(input bit b, input bit r);
      @(negedge hwclk);
      if (!r && reset_btn) begin
         reset_btn = 1'b0;
         btn_in = b;
         #1;
         checks++;
         if ({btn_level, btn_press, btn_release, btn_long} != 4'b0000) begin
            errors++;
            $display("FAIL async_reset got %b want 0000", {btn_level, btn_press, btn_release, btn_long});
         end
      end
      reset_btn = r;
      btn_in = b;
      model_edge(b, r);
      started = 1;
   endtask

   task automatic hold(input bit b, input int n);
      repeat (n) step(b, 1'b1);
   endtask

   always @(posedge hwclk) begin
      #1;
      if (started) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got output %b with no expectation", {btn_level, btn_press, btn_release, btn_long});
         end else begin
            mon_exp = exp_q.pop_front();
            if ({btn_level, btn_press, btn_release, btn_long} !== mon_exp) begin
               errors++;
               $display("FAIL outputs t=%0t level/press/release/long got %b want %b", $time, {btn_level, btn_press, btn_release, btn_long}, mon_exp);
            end
         end
      end
   end

   initial begin
      repeat (3) step(1'b0, 1'b0);
      hold(1'b0, 3);
      hold(1'b1, 30);
      hold(1'b0, 12);
      hold(1'b1, 3);
      hold(1'b0, 12);
      hold(1'b1, 12);
      step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
      hold(1'b0, 12);
      hold(1'b1, 3);
      step(1'b1, 1'b0);
      hold(1'b1, 14);
      hold(1'b0, 12);
      repeat (300) begin
         if ($urandom_range(0, 40) == 0) step(1'($urandom_range(0, 1)), 1'b0);
         else hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 16)));
      end
      @(posedge hwclk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
